nibble_add_seq: RTL and testbench
=================================

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port start_i  input  1  request to begin an operation; qualified by ready_o.
REQ-005 Port ready_o  output  1  block can accept start_i this cycle.
REQ-006 Port sub_i  input  1  0 = add, 1 = subtract (a - b); sampled on acceptance.
REQ-007 Port a_i  input  W  operand A; sampled on acceptance.
REQ-008 Port b_i  input  W  operand B; sampled on acceptance.
REQ-009 Port sum_o  output  W  result; stable while out_valid_o is high.
REQ-010 Port cout_o  output  1  carry out of the MSB slice (add: carry; sub: 1 = no borrow).
REQ-011 Port ovf_o  output  1  two's-complement signed overflow of the result.
REQ-012 Port out_valid_o  output  1  result available; held until taken.
REQ-013 Port out_ready_i  input  1  consumer takes the result when out_valid_o and out_ready_i are both high.
REQ-014 Port busy_o  output  1  high while in RUN.

Function
REQ-015 The block SHALL compute the W-bit sum/difference nibble-serially with exactly one instance of the team's 4-bit ripple-carry adder (RCA4), one nibble per clock, LSB nibble first.
REQ-016 The FSM SHALL have states IDLE, RUN, DONE; encoding is free.
REQ-017 ready_o SHALL be 1 in IDLE, equal out_ready_i in DONE, and 0 in RUN (combinational).
REQ-018 Acceptance occurs on a rising edge with start_i and ready_o high: a_i, b_i, sub_i latched; carry register loaded with sub_i; nibble index cleared to 0; state -> RUN.
REQ-019 In RUN, each edge SHALL apply A[idx], B[idx] XOR {4{sub}}, carry to the adder, write the 4-bit sum into result nibble idx, update the carry register from the adder carry-out, and increment idx.
REQ-020 After the edge processing nibble NIBBLES-1, state -> DONE, out_valid_o = 1; latency is exactly NIBBLES cycles from the acceptance edge to out_valid_o high.
REQ-021 cout_o SHALL equal the final carry; ovf_o SHALL equal the carry into the MSB bit XOR the carry out of the MSB bit, computed on the last nibble and registered.
REQ-022 In DONE, sum_o/cout_o/ovf_o/out_valid_o SHALL hold until out_ready_i is high; on that edge: if start_i is also high, a new operation is accepted (state -> RUN, out_valid_o -> 0); otherwise state -> IDLE, out_valid_o -> 0.
REQ-023 start_i while in RUN SHALL be ignored with no effect on the operation in progress.
REQ-024 out_ready_i outside DONE SHALL be ignored.
REQ-025 Operand changes on a_i/b_i/sub_i after acceptance SHALL not affect the result.
REQ-026 sum_o, cout_o, ovf_o SHALL retain the last completed result after leaving DONE until the next operation's first nibble is written.
REQ-027 busy_o = 1 exactly in RUN; out_valid_o = 1 exactly in DONE.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, idx 0, carry 0, sum_o 0, cout_o 0, ovf_o 0, out_valid_o 0, busy_o 0, ready_o 1, independent of clk.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort the operation; no partial result is presented after reset release.
REQ-030 First acceptance is possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 Add: a=0x1234, b=0x1111, sub=0 -> after 4 cycles out_valid_o=1, sum_o=0x2345, cout_o=0, ovf_o=0.
REQ-032 Carry wrap: a=0xFFFF, b=0x0001, sub=0 -> sum_o=0x0000, cout_o=1, ovf_o=0.
REQ-033 Subtract: a=0x0005, b=0x0007, sub=1 -> sum_o=0xFFFE, cout_o=0 (borrow), ovf_o=0; a=0x8000, b=0x0001, sub=1 -> sum_o=0x7FFF, ovf_o=1.
REQ-034 Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> sum_o=0x8000, cout_o=0, ovf_o=1.
REQ-035 Backpressure/back-to-back: hold out_ready_i=0 for 3 cycles in DONE -> outputs stable; then out_ready_i=1 with start_i=1 (a=0x0F0F, b=0x00F1) -> new op accepted same edge, sum_o=0x1000 4 cycles later; start_i pulsed during RUN ignored.
REQ-036 Reset mid-op: assert rst_n=0 after 2 RUN cycles -> all outputs 0, ready_o=1 immediately; post-release op 0x0001+0x0001 -> sum_o=0x0002.

Source files
------------

// File: rtl/nibble_add_seq.sv
// Nibble-serial W-bit adder/subtractor: one 4-bit ripple-carry slice reused
// over NIBBLES clocks, LSB nibble first, with a valid/ready result handshake.

module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c_msb
);
  logic [4:0] c;

  // NOTE: blocking assignments here are intentional; each carry feeds the next bit within the same evaluation.
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout  = c[4];
    c_msb = c[3];
  end
endmodule

module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic                 ready_o,
  input  logic                 sub_i,
  input  logic [4*NIBBLES-1:0] a_i,
  input  logic [4*NIBBLES-1:0] b_i,
  output logic [4*NIBBLES-1:0] sum_o,
  output logic                 cout_o,
  output logic                 ovf_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_q, b_q, sum_q;
  logic             sub_q, carry, cout_q, ovf_q;
  logic [3:0]       a_nib, b_nib, s_nib;
  logic             co, c_msb;
  logic             accept;

  assign ready_o     = (state == IDLE) || ((state == DONE) && out_ready_i);
  assign accept      = start_i && ready_o;
  assign busy_o      = (state == RUN);
  assign out_valid_o = (state == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IDX_W'(n)) begin
        a_nib = a_q[n*4 +: 4];
        b_nib = b_q[n*4 +: 4];
      end
    end
    b_nib = b_nib ^ {4{sub_q}};
  end

  rca4 u_rca4 (
    .a     (a_nib),
    .b     (b_nib),
    .cin   (carry),
    .s     (s_nib),
    .cout  (co),
    .c_msb (c_msb)
  );

  // NOTE: operand registers are reset too; reset must leave no trace of an aborted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) sum_q[n*4 +: 4] <= s_nib;
          end
          carry <= co;
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state  <= DONE;
            cout_q <= co;
            ovf_q  <= c_msb ^ co;
          end
        end
        IDLE, DONE: begin
          if (accept) begin
            state <= RUN;
            a_q   <= a_i;
            b_q   <= b_i;
            sub_q <= sub_i;
            carry <= sub_i;
            idx   <= '0;
          end else if (state == DONE && out_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.

module tb_nibble_add_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, sub_i, out_ready_i;
  logic [15:0] a_i, b_i;
  logic        ready_o, cout_o, ovf_o, out_valid_o, busy_o;
  logic [15:0] sum_o;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } result_t;

  result_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  nibble_add_seq #(.NIBBLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .ready_o     (ready_o),
    .sub_i       (sub_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .sum_o       (sum_o),
    .cout_o      (cout_o),
    .ovf_o       (ovf_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: a result is consumed on the next rising edge when valid and ready are both high.
  initial begin
    result_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(sum_o), 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("sum",  32'(sum_o),  32'(e.sum));
          check("cout", 32'(cout_o), 32'(e.cout));
          check("ovf",  32'(ovf_o),  32'(e.ovf));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue an operation, verify exact 4-cycle latency, leave the result in DONE.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic [15:0] es, input logic ec, input logic eo);
    int guard = 0;
    while (!ready_o && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before_start", 32'(ready_o), 32'd1);
    a_i = a; b_i = b; sub_i = sub; start_i = 1'b1;
    exp_q.push_back('{sum: es, cout: ec, ovf: eo});
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) check("valid_during_run", 32'(out_valid_o), 32'd0);
    end
    check("valid_after_4", 32'(out_valid_o), 32'd1);
    check("busy_in_done", 32'(busy_o), 32'd0);
  endtask

  task automatic take();
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    check("valid_after_take", 32'(out_valid_o), 32'd0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [15:0] es, input logic ec, input logic eo);
    issue(a, b, sub, es, ec, eo);
    take();
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; sub_i = 1'b0; out_ready_i = 1'b0;
    a_i = '0; b_i = '0;
    #12;
    check("rst_sum",   32'(sum_o),       32'd0);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy",  32'(busy_o),      32'd0);
    check("rst_ready", 32'(ready_o),     32'd1);
    rst_n = 1'b1;
    #1;

    run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    check("retain_after_done", 32'(sum_o), 32'h0000);

    // Backpressure, then back-to-back acceptance on the same handshake edge.
    issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid_o), 32'd1);
      check("hold_sum",   32'(sum_o),       32'h2345);
      check("hold_ready", 32'(ready_o),     32'd0);
    end
    a_i = 16'h0F0F; b_i = 16'h00F1; sub_i = 1'b0; start_i = 1'b1; out_ready_i = 1'b1;
    exp_q.push_back('{sum: 16'h1000, cout: 1'b0, ovf: 1'b0});
    @(posedge clk); #1;
    start_i = 1'b0; out_ready_i = 1'b0;
    check("b2b_busy",   32'(busy_o),      32'd1);
    check("b2b_valid",  32'(out_valid_o), 32'd0);
    check("b2b_retain", 32'(sum_o),       32'h2345);
    a_i = 16'hAAAA; b_i = 16'h5555; sub_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      start_i = (k == 2);
      out_ready_i = (k == 1);
      if (k < 4) check("run_ready", 32'(ready_o), 32'd0);
      @(posedge clk); #1;
    end
    start_i = 1'b0; out_ready_i = 1'b0;
    check("b2b_valid_after_4", 32'(out_valid_o), 32'd1);
    take();
    check("idle_after_take", 32'(busy_o), 32'd0);

    // Reset in the middle of RUN aborts the operation.
    a_i = 16'hAAAA; b_i = 16'h5555; sub_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum",   32'(sum_o),       32'd0);
    check("mid_rst_cout",  32'(cout_o),      32'd0);
    check("mid_rst_ovf",   32'(ovf_o),       32'd0);
    check("mid_rst_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_busy",  32'(busy_o),      32'd0);
    check("mid_rst_ready", 32'(ready_o),     32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
